// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array tile sequencer: state encoding,
// default geometry constants and the tile-count helper.
`timescale 1ns/1ps
package tpu_pkg;

  localparam int TPU_SA_DIM    = 4;
  localparam int TPU_ELEM_BITS = 8;
  localparam int TPU_ACC_BITS  = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    ACCUM,
    WRITE,
    NEXT_TILE
  } tpu_state_e;

  // Number of tiles of edge b needed to cover a dimension of size a.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/tpu_tile_loader.sv
// Operand tile loader: walks the SA_DIM slots of one K-tile, drives the A/B
// buffer addresses and captures the returned words one cycle later. Slots
// past the end of K are zero-filled while their addresses are still driven.
// The phase lasts SA_DIM+1 cycles while start_i is held; done_o marks the last.
`timescale 1ns/1ps
module tpu_tile_loader
  import tpu_pkg::*;
#(
  parameter int SA_DIM    = TPU_SA_DIM,
  parameter int ELEM_BITS = TPU_ELEM_BITS,
  parameter int ADDR_BITS = 16,
  parameter int DIM_BITS  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_i,
  output logic                                 done_o,
  input  logic [DIM_BITS-1:0]                  k_dim_i,
  input  logic [DIM_BITS-1:0]                  kt_i,
  input  logic [DIM_BITS-1:0]                  mt_i,
  input  logic [DIM_BITS-1:0]                  nt_i,
  output logic [ADDR_BITS-1:0]                 a_addr_o,
  output logic [ADDR_BITS-1:0]                 b_addr_o,
  input  logic [SA_DIM*ELEM_BITS-1:0]          a_rdata_i,
  input  logic [SA_DIM*ELEM_BITS-1:0]          b_rdata_i,
  output logic [SA_DIM*SA_DIM*ELEM_BITS-1:0]   a_tile_o,
  output logic [SA_DIM*SA_DIM*ELEM_BITS-1:0]   b_tile_o
);

  localparam int SLOT_W = SA_DIM * ELEM_BITS;
  localparam int TILE_W = SA_DIM * SLOT_W;
  localparam int CW     = $clog2(SA_DIM + 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TILE_W-1:0] a_tile_q, a_tile_d;
  logic [TILE_W-1:0] b_tile_q, b_tile_d;
  logic [31:0]       k_issue;
  logic [31:0]       k_cap;

  // Address of the slot being issued this cycle; capture targets the previous slot.
  always_comb begin
    k_issue  = 32'(kt_i) * 32'(SA_DIM) + 32'(cnt_q);
    k_cap    = k_issue - 32'd1;
    a_addr_o = ADDR_BITS'(32'(mt_i) * 32'(k_dim_i) + k_issue);
    b_addr_o = ADDR_BITS'(32'(nt_i) * 32'(k_dim_i) + k_issue);
    done_o   = start_i && (cnt_q == CW'(SA_DIM));
  end

  // Slot counter advance and capture of read data into the addressed slot.
  always_comb begin
    cnt_d    = cnt_q;
    a_tile_d = a_tile_q;
    b_tile_d = b_tile_q;
    if (start_i) begin
      cnt_d = (cnt_q == CW'(SA_DIM)) ? '0 : cnt_q + CW'(1);
      for (int i = 0; i < SA_DIM; i++) begin
        if (cnt_q == CW'(i + 1)) begin
          if (k_cap >= 32'(k_dim_i)) begin
            a_tile_d[i*SLOT_W +: SLOT_W] = '0;
            b_tile_d[i*SLOT_W +: SLOT_W] = '0;
          end else begin
            a_tile_d[i*SLOT_W +: SLOT_W] = a_rdata_i;
            b_tile_d[i*SLOT_W +: SLOT_W] = b_rdata_i;
          end
        end
      end
    end
  end

  // Loader state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_tile_q <= '0;
      b_tile_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      a_tile_q <= a_tile_d;
      b_tile_q <= b_tile_d;
    end
  end

  assign a_tile_o = a_tile_q;
  assign b_tile_o = b_tile_q;

endmodule

// File: rtl/tpu_tile_ctrl.sv
// Tile sequencer for an SA_DIM x SA_DIM systolic array. Walks N-tiles (outer),
// M-tiles, K-tiles (inner); loads operands, runs the array, accumulates partial
// sums across K-tiles and writes each finished tile row by row to the C buffer.
// Build option: define TPU_RELU_EN to clamp negative C lanes to zero on write.
`timescale 1ns/1ps
module tpu_tile_ctrl
  import tpu_pkg::*;
#(
  parameter int SA_DIM    = TPU_SA_DIM,
  parameter int ELEM_BITS = TPU_ELEM_BITS,
  parameter int ACC_BITS  = TPU_ACC_BITS,
  parameter int ADDR_BITS = 16,
  parameter int DIM_BITS  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [DIM_BITS-1:0]                  K,
  input  logic [DIM_BITS-1:0]                  M,
  input  logic [DIM_BITS-1:0]                  N,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 sa_rst_n,
  input  logic                                 sa_done,
  output logic [ADDR_BITS-1:0]                 a_addr,
  output logic [ADDR_BITS-1:0]                 b_addr,
  input  logic [SA_DIM*ELEM_BITS-1:0]          a_rdata,
  input  logic [SA_DIM*ELEM_BITS-1:0]          b_rdata,
  output logic [SA_DIM*SA_DIM*ELEM_BITS-1:0]   a_tile,
  output logic [SA_DIM*SA_DIM*ELEM_BITS-1:0]   b_tile,
  input  logic [SA_DIM*SA_DIM*ACC_BITS-1:0]    sa_result,
  output logic                                 c_wr_en,
  output logic [ADDR_BITS-1:0]                 c_addr,
  output logic [SA_DIM*ACC_BITS-1:0]           c_wdata
);

  localparam int RW    = $clog2(SA_DIM);
  localparam int ROW_W = SA_DIM * ACC_BITS;
  localparam int ACC_W = SA_DIM * ROW_W;

  tpu_state_e          state_q, state_d;
  logic [DIM_BITS-1:0] k_q, m_q;
  logic [DIM_BITS-1:0] ktiles_q, mtiles_q, ntiles_q;
  logic [DIM_BITS-1:0] kt_q, mt_q, nt_q;
  logic [RW-1:0]       row_q;
  logic [ACC_W-1:0]    acc_q;
  logic                done_q;
  logic                c_wr_en_q;
  logic [ADDR_BITS-1:0] c_addr_q;
  logic [ROW_W-1:0]    c_wdata_q;
  logic                ld_start;
  logic                ld_done;
  logic                job_ok;
  logic                kt_last;
  logic                last_tile;
  logic                row_ok;

  // Optionally clamp negative signed lanes of a C row to zero.
  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
    logic [ROW_W-1:0] res;
`ifdef TPU_RELU_EN
    logic signed [ACC_BITS-1:0] lane;
`endif
    res = row;
`ifdef TPU_RELU_EN
    for (int l = 0; l < SA_DIM; l++) begin
      lane = row[l*ACC_BITS +: ACC_BITS];
      if (lane < 0) res[l*ACC_BITS +: ACC_BITS] = '0;
    end
`endif
    return res;
  endfunction

  tpu_tile_loader #(
    .SA_DIM    (SA_DIM),
    .ELEM_BITS (ELEM_BITS),
    .ADDR_BITS (ADDR_BITS),
    .DIM_BITS  (DIM_BITS)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (ld_start),
    .done_o    (ld_done),
    .k_dim_i   (k_q),
    .kt_i      (kt_q),
    .mt_i      (mt_q),
    .nt_i      (nt_q),
    .a_addr_o  (a_addr),
    .b_addr_o  (b_addr),
    .a_rdata_i (a_rdata),
    .b_rdata_i (b_rdata),
    .a_tile_o  (a_tile),
    .b_tile_o  (b_tile)
  );

  // Decode helpers shared by the next-state logic and the datapath registers.
  always_comb begin
    job_ok    = (K != '0) && (M != '0) && (N != '0);
    kt_last   = (kt_q == ktiles_q - DIM_BITS'(1));
    last_tile = (mt_q == mtiles_q - DIM_BITS'(1)) && (nt_q == ntiles_q - DIM_BITS'(1));
    row_ok    = (32'(mt_q) * 32'(SA_DIM) + 32'(row_q)) < 32'(m_q);
    ld_start  = (state_q == LOAD);
  end

  // Next-state selection for the tile walk.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (in_valid && job_ok) state_d = LOAD;
      LOAD:      if (ld_done) state_d = RUN;
      RUN:       if (sa_done) state_d = ACCUM;
      ACCUM:     state_d = kt_last ? WRITE : LOAD;
      WRITE:     if (row_q == RW'(SA_DIM - 1)) state_d = NEXT_TILE;
      NEXT_TILE: state_d = last_tile ? IDLE : LOAD;
      default:   state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Job latch, tile counters, accumulators and registered C write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= '0;
      m_q       <= '0;
      ktiles_q  <= '0;
      mtiles_q  <= '0;
      ntiles_q  <= '0;
      kt_q      <= '0;
      mt_q      <= '0;
      nt_q      <= '0;
      row_q     <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      c_wr_en_q <= 1'b0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
    end else begin
      done_q    <= 1'b0;
      c_wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            k_q      <= K;
            m_q      <= M;
            ktiles_q <= DIM_BITS'(ceil_div(32'(K), 32'(SA_DIM)));
            mtiles_q <= DIM_BITS'(ceil_div(32'(M), 32'(SA_DIM)));
            ntiles_q <= DIM_BITS'(ceil_div(32'(N), 32'(SA_DIM)));
            kt_q     <= '0;
            mt_q     <= '0;
            nt_q     <= '0;
            row_q    <= '0;
            acc_q    <= '0;
            if (!job_ok) done_q <= 1'b1;
          end
        end
        ACCUM: begin
          for (int i = 0; i < SA_DIM * SA_DIM; i++)
            acc_q[i*ACC_BITS +: ACC_BITS] <= acc_q[i*ACC_BITS +: ACC_BITS]
                                           + sa_result[i*ACC_BITS +: ACC_BITS];
          if (!kt_last) kt_q <= kt_q + DIM_BITS'(1);
        end
        WRITE: begin
          c_wr_en_q <= row_ok;
          c_addr_q  <= ADDR_BITS'(32'(nt_q) * 32'(m_q) + 32'(mt_q) * 32'(SA_DIM) + 32'(row_q));
          c_wdata_q <= relu_row(acc_q[32'(row_q)*ROW_W +: ROW_W]);
          row_q     <= row_q + RW'(1);
        end
        NEXT_TILE: begin
          acc_q <= '0;
          kt_q  <= '0;
          row_q <= '0;
          if (mt_q != mtiles_q - DIM_BITS'(1)) begin
            mt_q <= mt_q + DIM_BITS'(1);
          end else begin
            mt_q <= '0;
            nt_q <= nt_q + DIM_BITS'(1);
          end
          if (last_tile) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign sa_rst_n = (state_q == RUN);
  assign done     = done_q;
  assign c_wr_en  = c_wr_en_q;
  assign c_addr   = c_addr_q;
  assign c_wdata  = c_wdata_q;

endmodule

// File: tb/tb_tpu_tile_ctrl.sv
// Bench for tpu_tile_ctrl: random A/B buffers with 1-cycle read latency, a
// behavioural array that multiplies the presented operand tiles, and a
// scoreboard of expected C writes built from plain matrix arithmetic.
`timescale 1ns/1ps
module tb_tpu_tile_ctrl;

  localparam int SA     = 4;
  localparam int EB     = 8;
  localparam int AB     = 32;
  localparam int ADB    = 16;
  localparam int DB     = 8;
  localparam int SLOT_W = SA * EB;
  localparam int TILE_W = SA * SLOT_W;
  localparam int ROW_W  = SA * AB;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic [DB-1:0]      K, M, N;
  logic               busy, done, sa_rst_n, sa_done;
  logic [ADB-1:0]     a_addr, b_addr, c_addr;
  logic [SLOT_W-1:0]  a_rdata, b_rdata;
  logic [TILE_W-1:0]  a_tile, b_tile;
  logic [SA*ROW_W-1:0] sa_result;
  logic               c_wr_en;
  logic [ROW_W-1:0]   c_wdata;

  typedef struct packed {
    logic [ADB-1:0]   addr;
    logic [ROW_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  int                checks;
  int                errors;
  logic [SLOT_W-1:0] amem[256];
  logic [SLOT_W-1:0] bmem[256];

  tpu_tile_ctrl #(
    .SA_DIM(SA), .ELEM_BITS(EB), .ACC_BITS(AB), .ADDR_BITS(ADB), .DIM_BITS(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .K(K), .M(M), .N(N),
    .busy(busy), .done(done), .sa_rst_n(sa_rst_n), .sa_done(sa_done),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .a_tile(a_tile), .b_tile(b_tile), .sa_result(sa_result),
    .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wdata(c_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // C[m][n] restricted to one tile row: sum over k of A(m,k)*B(k,n), with the
  // buffer layout A word = mt*K+k (element r), B word = nt*K+k (element l).
  function automatic logic [ROW_W-1:0] ref_row(input int k, input int mt, input int nt, input int r);
    logic [ROW_W-1:0]  res;
    logic [SLOT_W-1:0] wa, wb;
    logic signed [EB-1:0] ea, eb;
    int s;
    res = '0;
    for (int l = 0; l < SA; l++) begin
      s = 0;
      for (int kk = 0; kk < k; kk++) begin
        wa = amem[(mt * k + kk) & 255];
        wb = bmem[(nt * k + kk) & 255];
        ea = wa[r*EB +: EB];
        eb = wb[l*EB +: EB];
        s += int'(ea) * int'(eb);
      end
`ifdef TPU_RELU_EN
      if (s < 0) s = 0;
`endif
      res[l*AB +: AB] = s;
    end
    return res;
  endfunction

  // Behavioural array: outer-product sum of the presented operand slots.
  function automatic logic [SA*ROW_W-1:0] array_mul(input logic [TILE_W-1:0] at, input logic [TILE_W-1:0] bt);
    logic [SA*ROW_W-1:0] res;
    logic signed [EB-1:0] ea, eb;
    int s;
    res = '0;
    for (int r = 0; r < SA; r++)
      for (int l = 0; l < SA; l++) begin
        s = 0;
        for (int i = 0; i < SA; i++) begin
          ea = at[i*SLOT_W + r*EB +: EB];
          eb = bt[i*SLOT_W + l*EB +: EB];
          s += int'(ea) * int'(eb);
        end
        res[(r*SA + l)*AB +: AB] = s;
      end
    return res;
  endfunction

  // Operand buffers: data for the address seen last cycle.
  initial begin
    logic [ADB-1:0] pa, pb;
    pa = '0; pb = '0; a_rdata = '0; b_rdata = '0;
    forever begin
      @(negedge clk);
      a_rdata = amem[pa[7:0]];
      b_rdata = bmem[pb[7:0]];
      pa = a_addr;
      pb = b_addr;
    end
  end

  // Array model: random run length, result held until the next run, stray
  // sa_done pulses while the array is held in clear.
  initial begin
    int dly;
    bit fired;
    sa_done = 1'b0; sa_result = '0; fired = 1'b0; dly = 0;
    forever begin
      @(negedge clk);
      if (sa_rst_n === 1'b1) begin
        if (fired) sa_done = 1'b0;
        else if (dly == 0) begin
          sa_result = array_mul(a_tile, b_tile);
          sa_done = 1'b1;
          fired = 1'b1;
        end else begin
          dly--;
          sa_done = 1'b0;
        end
      end else begin
        fired = 1'b0;
        dly = $urandom_range(0, 3);
        sa_done = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // Monitor: every C write must match the head of the expected queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (c_wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0h data=%h expected no write", c_addr, c_wdata);
        end else begin
          e = exp_q.pop_front();
          if (c_addr !== e.addr || c_wdata !== e.data) begin
            errors++;
            $display("FAIL c_write got addr=%0h data=%h expected addr=%0h data=%h",
                     c_addr, c_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic push_expected(input int k, input int m, input int n);
    wr_t e;
    for (int nt = 0; nt < (n + SA - 1) / SA; nt++)
      for (int mt = 0; mt < (m + SA - 1) / SA; mt++)
        for (int r = 0; r < SA; r++)
          if (mt * SA + r < m) begin
            e.addr = ADB'(nt * m + mt * SA + r);
            e.data = ref_row(k, mt, nt, r);
            exp_q.push_back(e);
          end
  endtask

  task automatic run_job(input int k, input int m, input int n);
    int  cyc;
    bit  seen;
    bit  nz;
    nz = (k > 0) && (m > 0) && (n > 0);
    if (nz) push_expected(k, m, n);
    in_valid = 1'b1; K = DB'(k); M = DB'(m); N = DB'(n);
    @(negedge clk);
    in_valid = 1'b0;
    if (!nz) begin
      chk("zero_dim_done", done, 1);
      chk("zero_dim_busy", busy, 0);
      @(negedge clk);
      chk("zero_dim_done_clear", done, 0);
    end else begin
      chk("busy_after_accept", busy, 1);
      chk("done_low_while_busy", done, 0);
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (done === 1'b1) seen = 1'b1;
        else begin
          in_valid = ($urandom_range(0, 3) == 0);
          K = DB'($urandom); M = DB'($urandom); N = DB'($urandom);
        end
      end
      in_valid = 1'b0;
      chk("done_seen", seen, 1);
      chk("busy_low_with_done", busy, 0);
      chk("writes_drained", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    int cyc;
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; K = '0; M = '0; N = '0;
    for (int i = 0; i < 256; i++) begin
      amem[i] = SLOT_W'($urandom);
      bmem[i] = SLOT_W'($urandom);
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sa_rst_n", sa_rst_n, 0);
    chk("rst_c_wr_en", c_wr_en, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_b_addr", b_addr, 0);
    chk("rst_c_addr", c_addr, 0);
    chk("rst_a_tile", a_tile, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(4, 4, 4);
    run_job(8, 4, 4);
    run_job(6, 4, 4);
    run_job(4, 6, 4);
    run_job(5, 3, 7);
    run_job(0, 4, 4);
    run_job(4, 0, 4);
    run_job(4, 4, 0);

    // Abort in RUN of a K=8 job; nothing may be written afterwards.
    in_valid = 1'b1; K = 8; M = 4; N = 4;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (sa_rst_n !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_run", sa_rst_n, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_sa_rst_n", sa_rst_n, 0);
    chk("abort_c_wr_en", c_wr_en, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    run_job(4, 4, 4);

    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < 256; i++) begin
        amem[i] = SLOT_W'($urandom);
        bmem[i] = SLOT_W'($urandom);
      end
      run_job($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_tile_ctrl.md
Name: tpu_tile_ctrl

Overview:
Parametrised tile sequencer for an SA_DIM x SA_DIM systolic array. It accepts a K/M/N job and walks the tiles in order N-tile (outer), M-tile, K-tile (inner). For each K-tile it fetches A/B operand words into local tile registers and runs the array; partial sums accumulate across K-tiles. When K is exhausted, the tile result is written to the C buffer. All logic runs on the posedge of one clock. Ragged edges in K, M and N are handled by zero-padding and write suppression.

Parameters:
SA_DIM, 4, array edge; power of two, 2..16
ELEM_BITS, 8, operand element width
ACC_BITS, 32, accumulator lane width
ADDR_BITS, 16, buffer address width
DIM_BITS, 8, width of K/M/N

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  job start, sampled only in IDLE
K, M, N  in  DIM_BITS each  job dimensions, latched on accept
busy  out  1  high from the cycle after accept until return to IDLE
done  out  1  one-cycle pulse on job completion
sa_rst_n  out  1  array clear/run; low clears, high runs
sa_done  in  1  array finished current tile
a_addr, b_addr  out  ADDR_BITS  operand buffer read addresses
a_rdata, b_rdata  in  SA_DIM*ELEM_BITS  read data, 1-cycle latency
a_tile, b_tile  out  SA_DIM*SA_DIM*ELEM_BITS  local operand tiles to array; slot i = bits [i*SA_DIM*ELEM_BITS +: SA_DIM*ELEM_BITS]
sa_result  in  SA_DIM*SA_DIM*ACC_BITS  array results; row r = bits [r*SA_DIM*ACC_BITS +: SA_DIM*ACC_BITS]
c_wr_en  out  1  C write strobe
c_addr  out  ADDR_BITS  C write address
c_wdata  out  SA_DIM*ACC_BITS  C write data

Behaviour:
- Reset: state IDLE. busy=0, done=0, sa_rst_n=0, c_wr_en=0. All addresses, tiles and accumulators are 0. Reset mid-job aborts immediately and performs no further writes.
- Tile counts are ceil(dim/SA_DIM), computed on accept. Buffer layout:
  - A address = mt*K + k
  - B address = nt*K + k
  - C address = nt*M + mt*SA_DIM + r
- IDLE: on in_valid, latch K/M/N and clear counters.
  - Any dimension = 0: pulse done next cycle, stay IDLE, no writes.
  - in_valid while not IDLE is ignored.
- LOAD (SA_DIM+1 cycles): issue addresses for slots i=0..SA_DIM-1, then capture each slot one cycle later.
  - Slot k = kt*SA_DIM+i with k >= K is forced to 0; its address is still driven.
  - sa_rst_n=0 throughout.
- RUN: sa_rst_n=1; wait for sa_done. No timeout. sa_done outside RUN is ignored.
- ACCUM (1 cycle): acc[r] += sa_result row r, lane-wise modulo 2^ACC_BITS. sa_rst_n=0.
  - If kt < ktiles-1: increment kt and go to LOAD.
  - Otherwise go to WRITE.
- WRITE: SA_DIM cycles, r=0..SA_DIM-1.
  - c_wr_en=1, c_addr and c_wdata registered together.
  - c_wr_en=0 for rows with mt*SA_DIM+r >= M.
- NEXT_TILE: clear acc and kt.
  - mt < mtiles-1: increment mt.
  - Otherwise mt=0 and increment nt.
  - Past the last nt: pulse done, go to IDLE.
- busy drops in the same cycle done pulses.
- Best-case latency per K-tile = SA_DIM+1 (LOAD) + run + 1 (ACCUM); WRITE + NEXT_TILE add SA_DIM+1 cycles per output tile.
- Address arithmetic is truncated to ADDR_BITS (wraps).

Optional Feature:
- TPU_RELU_EN defined: during WRITE, each ACC_BITS lane of c_wdata that is negative (signed) is replaced by 0.
- Undefined: raw accumulator values are written. No port change either way.

Decomposition:
- Package tpu_pkg holds:
  - state enum (IDLE, LOAD, RUN, ACCUM, WRITE, NEXT_TILE)
  - default SA_DIM/ELEM_BITS/ACC_BITS constants
  - function ceil_div
- Sub-module tpu_tile_loader: owns the LOAD phase (address issue, capture, zero-pad). It has start/done handshake with the FSM, kt/mt/nt inputs, and outputs a_tile/b_tile.

Test Plan:
- K=M=N=4, A=B=identity, sa_result = I each run -> 4 C writes at addresses 0..3, row r has 1 in lane r, done pulse, busy low.
- K=8, M=N=4, sa_result all 1s per run -> one accumulation pass (two runs), C lanes = 2, exactly 4 writes.
- K=6 -> slots 2,3 of the second K-tile read as 0 in a_tile/b_tile although addresses 6,7 are driven.
- M=6, N=4 -> writes at 0..3 then 4,5 only (rows 6,7 suppressed); tile order mt0 then mt1.
- Reset asserted in RUN of a K=8 job -> next cycle IDLE, busy=0, no c_wr_en; new K=M=N=4 job completes correctly.
- With TPU_RELU_EN, sa_result lane = -5 -> c_wdata lane 0; without the macro -> 0xFFFFFFFB.
